// File: rtl/tdm_pkg.sv
// rtl/tdm_pkg.sv - shared types and defaults for the TDM receive demultiplexer
// Contents: default channel count/width, FSM state type, counter width helper.
package tdm_pkg;

    localparam int TDM_N_CH = 4;
    localparam int TDM_W    = 8;

    typedef enum logic [0:0] {
        HUNT    = 1'b0,
        COLLECT = 1'b1
    } tdm_state_t;

    // Width of a counter/selector able to index n entries; never below 1 bit.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/demux_onehot.sv
// rtl/demux_onehot.sv - combinational 1-to-N one-hot write-enable decoder
// Ports:
//   sel : index of the entry to enable
//   en  : global enable; when low every output is low
//   we  : one-hot (or all-zero) write enables, we[k] = en & (sel == k)
module demux_onehot
    import tdm_pkg::*;
#(
    parameter int N  = 4,
    parameter int SW = cnt_width(N)
) (
    input  logic [SW-1:0] sel,
    input  logic          en,
    output logic [N-1:0]  we
);

    always_comb begin
        we = '0;
        for (int k = 0; k < N; k++) begin
            we[k] = en && (sel == SW'(k));
        end
    end

endmodule

// File: rtl/tdm_demux.sv
// rtl/tdm_demux.sv - TDM word stream receiver: steers words into channel registers, publishes whole frames
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   in_valid   : in_data/in_sof carry a word this cycle
//   in_sof     : word is channel 0 of a new frame
//   in_data    : received channel word
//   out_data   : last complete frame, channel k at [k*W +: W]
//   out_valid  : one-cycle pulse, out_data just updated
//   out_err    : one-cycle pulse, early start-of-frame dropped a partial frame
module tdm_demux
    import tdm_pkg::*;
#(
    parameter int N_CH = TDM_N_CH,
    parameter int W    = TDM_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic              in_sof,
    input  logic [W-1:0]      in_data,
    output logic [N_CH*W-1:0] out_data,
    output logic              out_valid,
    output logic              out_err
);

    localparam int            CW   = cnt_width(N_CH);
    localparam logic [CW-1:0] LAST = CW'(N_CH - 1);

    tdm_state_t          state_q, state_d;
    logic [CW-1:0]       ch_cnt_q, ch_cnt_d;
    logic [W-1:0]        shadow_q [N_CH];
    logic [W-1:0]        shadow_d [N_CH];
    logic [N_CH*W-1:0]   out_data_q, out_data_d;
    logic                out_valid_q, out_valid_d;
    logic                out_err_q, out_err_d;

    logic [CW-1:0]       wr_sel;
    logic                wr_en;
    logic [N_CH-1:0]     wr_we;

    // A sof always lands in channel 0, whatever the counter says (resync).
    // Outside a frame, only a sof may write.
    assign wr_sel = in_sof ? '0 : ch_cnt_q;
    assign wr_en  = in_valid && (in_sof || (state_q == COLLECT));

    demux_onehot #(
        .N  (N_CH),
        .SW (CW)
    ) u_we_dec (
        .sel (wr_sel),
        .en  (wr_en),
        .we  (wr_we)
    );

    always_comb begin
        state_d     = state_q;
        ch_cnt_d    = ch_cnt_q;
        out_data_d  = out_data_q;
        out_valid_d = 1'b0;
        out_err_d   = 1'b0;

        for (int k = 0; k < N_CH; k++) begin
            shadow_d[k] = wr_we[k] ? in_data : shadow_q[k];
        end

        if (in_valid) begin
            case (state_q)
                HUNT: begin
                    if (in_sof) begin
                        ch_cnt_d = CW'(1);
                        state_d  = COLLECT;
                    end
                end
                COLLECT: begin
                    if (in_sof) begin
                        // Partial frame abandoned; this sof starts the new one.
                        out_err_d = 1'b1;
                        ch_cnt_d  = CW'(1);
                    end else if (ch_cnt_q == LAST) begin
                        // shadow_d already holds the final word of the frame.
                        for (int k = 0; k < N_CH; k++) begin
                            out_data_d[k*W +: W] = shadow_d[k];
                        end
                        out_valid_d = 1'b1;
                        ch_cnt_d    = '0;
                        state_d     = HUNT;
                    end else begin
                        ch_cnt_d = ch_cnt_q + CW'(1);
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= HUNT;
            ch_cnt_q    <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_err_q   <= 1'b0;
            for (int k = 0; k < N_CH; k++) begin
                shadow_q[k] <= '0;
            end
        end else begin
            state_q     <= state_d;
            ch_cnt_q    <= ch_cnt_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_err_q   <= out_err_d;
            for (int k = 0; k < N_CH; k++) begin
                shadow_q[k] <= shadow_d[k];
            end
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_err   = out_err_q;

endmodule
